// File: rtl/hsv_core_pkg.sv
// Shared issue/commit types: token, register masks and the per-instruction records.
// COMMON_DATA_T is shared with the commit stage so tokens and rd info line up.
package hsv_core_pkg;

   localparam int TOKEN_W  = 4;
   localparam int NUM_REGS = 32;

   typedef logic [TOKEN_W-1:0]          insn_token;
   typedef logic [NUM_REGS-1:0]         reg_mask;
   typedef logic [$clog2(NUM_REGS)-1:0] reg_addr;

   typedef struct packed {
      insn_token token;
      reg_addr   rd_addr;
      reg_mask   rd_mask;
   } common_data_t;

   typedef struct packed {
      common_data_t common;
      reg_mask      rs1_mask;
      reg_mask      rs2_mask;
      logic [31:0]  payload;
   } issue_data_t;

   // Issue input has the same layout; its token field is ignored and overwritten.
   typedef issue_data_t issue_insn_t;

   function automatic reg_mask insn_src_mask(input issue_insn_t insn);
      return insn.rs1_mask | insn.rs2_mask | insn.common.rd_mask;
   endfunction

endpackage

// File: rtl/hsv_core_issue_scoreboard.sv
// In-flight destination register scoreboard; hazard is combinational, pending updates in 1 cycle.
// HSV_ISSUE_COMMIT_BYPASS_EN lets same-cycle commit_mask clear hazards (commit-to-ready path).
module hsv_core_issue_scoreboard
   import hsv_core_pkg::*;
(
   input  logic    clk_core,
   input  logic    rst_core_n,
   input  logic    flush_req,
   input  logic    fire,
   input  reg_mask src_mask,
   input  reg_mask rd_mask,
   input  reg_mask commit_mask,
   output logic    hazard,
   output reg_mask pending_mask
);

   reg_mask busy;

   always_comb begin
`ifdef HSV_ISSUE_COMMIT_BYPASS_EN
      busy = pending_mask & ~commit_mask;
`else
      busy = pending_mask;
`endif
   end

   assign hazard = |(src_mask & busy);

   // New writer wins over a same-cycle release of the same register; x0 never tracked.
   always_ff @(posedge clk_core or negedge rst_core_n) begin
      if (!rst_core_n) begin
         pending_mask <= '0;
      end else if (flush_req) begin
         pending_mask <= '0;
      end else begin
         pending_mask <= (pending_mask & ~commit_mask)
                       | (fire ? (rd_mask & ~reg_mask'(1)) : '0);
      end
   end

endmodule

// File: rtl/hsv_core_issue_token.sv
// Issue token stamper: 1-cycle output register, stalls on RAW/WAW, full in-flight window or flush.
// Output held while out_ready_i is low; optional HSV_ISSUE_COMMIT_BYPASS_EN hazard bypass.
module hsv_core_issue_token
   import hsv_core_pkg::*;
#(
   parameter int MAX_INFLIGHT = 8
)
(
   input  logic        clk_core,
   input  logic        rst_core_n,
   input  logic        flush_req,
   output logic        flush_ack,
   input  issue_insn_t in_data,
   input  logic        in_valid_i,
   output logic        in_ready_o,
   output issue_data_t out_data,
   output logic        out_valid_o,
   input  logic        out_ready_i,
   input  reg_mask     commit_mask,
   input  logic        ctrl_commit,
   output reg_mask     pending_mask
);

   localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_INFLIGHT);

   if (MAX_INFLIGHT < 1 || MAX_INFLIGHT >= (1 << TOKEN_W)) begin : g_bad_cfg
      $error("MAX_INFLIGHT must be in [1, 2**TOKEN_W)");
   end

   insn_token        token;
   logic [CNT_W-1:0] inflight;
   logic [CNT_W-1:0] inflight_nxt;
   logic             hazard;
   logic             fire;
   issue_data_t      stamped;

   hsv_core_issue_scoreboard u_scoreboard (
      .clk_core     (clk_core),
      .rst_core_n   (rst_core_n),
      .flush_req    (flush_req),
      .fire         (fire),
      .src_mask     (insn_src_mask(in_data)),
      .rd_mask      (in_data.common.rd_mask),
      .commit_mask  (commit_mask),
      .hazard       (hazard),
      .pending_mask (pending_mask)
   );

   assign in_ready_o = !flush_req && !flush_ack && !hazard && (inflight < MAX_CNT)
                       && (!out_valid_o || out_ready_i);
   assign fire       = in_valid_i && in_ready_o;

   always_comb begin
      stamped              = in_data;
      stamped.common.token = token;
   end

   // A commit seen with nothing in flight is ignored so the count cannot underflow.
   always_comb begin
      inflight_nxt = inflight;
      if (fire) begin
         inflight_nxt = inflight_nxt + CNT_W'(1);
      end
      if (ctrl_commit && inflight != '0) begin
         inflight_nxt = inflight_nxt - CNT_W'(1);
      end
   end

   always_ff @(posedge clk_core or negedge rst_core_n) begin
      if (!rst_core_n) begin
         flush_ack   <= 1'b1;
         token       <= '0;
         inflight    <= '0;
         out_valid_o <= 1'b0;
         out_data    <= '0;
      end else begin
         flush_ack <= flush_req;
         if (flush_req) begin
            inflight    <= '0;
            out_valid_o <= 1'b0;
         end else begin
            inflight <= inflight_nxt;
            if (fire) begin
               out_valid_o <= 1'b1;
               out_data    <= stamped;
            end else if (out_ready_i) begin
               out_valid_o <= 1'b0;
            end
         end
         // Token restarts on the falling edge of the flush handshake, in step with commit.
         if (flush_ack && !flush_req) begin
            token <= '0;
         end else if (fire) begin
            token <= token + insn_token'(1);
         end
      end
   end

   a_commit_underflow: assert property (@(posedge clk_core) disable iff (!rst_core_n)
      !(ctrl_commit && !flush_req && inflight == '0));

endmodule

// File: tb/tb_hsv_core_issue_token.sv
module tb_hsv_core_issue_token;
   import hsv_core_pkg::*;

   logic        clk_core = 1'b0;
   logic        rst_core_n;
   logic        flush_req;
   logic        flush_ack;
   issue_insn_t in_data;
   logic        in_valid_i;
   logic        in_ready_o;
   issue_data_t out_data;
   logic        out_valid_o;
   logic        out_ready_i;
   reg_mask     commit_mask;
   logic        ctrl_commit;
   reg_mask     pending_mask;

   typedef struct packed {
      insn_token   tok;
      logic [31:0] pay;
      reg_mask     rd;
   } exp_t;

   exp_t        q[$];
   insn_token   exp_tok;
   logic [31:0] pay;
   int          n_cmp;
   int          n_err;

   hsv_core_issue_token #(.MAX_INFLIGHT(8)) dut (
      .clk_core     (clk_core),
      .rst_core_n   (rst_core_n),
      .flush_req    (flush_req),
      .flush_ack    (flush_ack),
      .in_data      (in_data),
      .in_valid_i   (in_valid_i),
      .in_ready_o   (in_ready_o),
      .out_data     (out_data),
      .out_valid_o  (out_valid_o),
      .out_ready_i  (out_ready_i),
      .commit_mask  (commit_mask),
      .ctrl_commit  (ctrl_commit),
      .pending_mask (pending_mask)
   );

   always #5 clk_core = ~clk_core;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Check in_ready for the current cycle, record the expected output, advance one clock.
   task automatic cycle(input string tag, input logic exp_rdy);
      exp_t e;
      #1;
      chk(tag, {63'd0, in_ready_o}, {63'd0, exp_rdy});
      if (in_valid_i && exp_rdy) begin
         e.tok = exp_tok;
         e.pay = in_data.payload;
         e.rd  = in_data.common.rd_mask;
         q.push_back(e);
         exp_tok = exp_tok + insn_token'(1);
      end
      @(posedge clk_core); #1;
   endtask

   task automatic tick();
      @(posedge clk_core); #1;
   endtask

   task automatic set_insn(input reg_mask rs1, input reg_mask rs2, input int rd);
      issue_insn_t i;
      i          = '0;
      i.rs1_mask = rs1;
      i.rs2_mask = rs2;
      if (rd >= 0) begin
         i.common.rd_addr = reg_addr'(rd);
         i.common.rd_mask = reg_mask'(1) << rd;
      end
      i.payload  = pay;
      pay        = pay + 32'd1;
      in_data    = i;
      in_valid_i = 1'b1;
   endtask

   task automatic idle_in();
      in_valid_i = 1'b0;
      in_data    = '0;
   endtask

   task automatic commit_n(input int n);
      for (int k = 0; k < n; k++) begin
         ctrl_commit = 1'b1;
         tick();
      end
      ctrl_commit = 1'b0;
   endtask

   // Scoreboard side: every dispatch handshake pops and checks the oldest expectation.
   always @(negedge clk_core) begin
      exp_t e;
      if (rst_core_n === 1'b1 && out_valid_o && out_ready_i) begin
         chk("out_has_expect", {63'd0, q.size() != 0}, 64'd1);
         if (q.size() != 0) begin
            e = q.pop_front();
            chk("out_token", {60'd0, out_data.common.token}, {60'd0, e.tok});
            chk("out_payload", {32'd0, out_data.payload}, {32'd0, e.pay});
            chk("out_rd_mask", {32'd0, out_data.common.rd_mask}, {32'd0, e.rd});
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL timeout: bench did not finish within its time budget");
      $fatal(1, "timeout");
   end

   initial begin
      n_cmp = 0; n_err = 0; exp_tok = '0; pay = 32'hC000;
      rst_core_n = 1'b0; flush_req = 1'b0; in_data = '0; in_valid_i = 1'b0;
      out_ready_i = 1'b1; commit_mask = '0; ctrl_commit = 1'b0;
      @(posedge clk_core); @(posedge clk_core); #1;

      // Reset state
      chk("rst_flush_ack", {63'd0, flush_ack}, 64'd1);
      chk("rst_out_valid", {63'd0, out_valid_o}, 64'd0);
      chk("rst_pending", {32'd0, pending_mask}, 64'd0);
      chk("rst_in_ready", {63'd0, in_ready_o}, 64'd0);
      rst_core_n = 1'b1;

      // Three back-to-back independent instructions
      set_insn('0, '0, 1);
      cycle("boot_cycle1", 1'b0);
      chk("boot_flush_ack_low", {63'd0, flush_ack}, 64'd0);
      cycle("b2b_a", 1'b1);
      set_insn('0, '0, 2);
      cycle("b2b_b", 1'b1);
      set_insn('0, '0, 3);
      cycle("b2b_c", 1'b1);
      idle_in();
      chk("b2b_pending", {32'd0, pending_mask}, 64'hE);
      commit_mask = 32'hE;
      commit_n(3);
      commit_mask = '0;
      chk("b2b_pending_clr", {32'd0, pending_mask}, 64'd0);

      // RAW on x5, release arrives 4 cycles after the writer issues
      set_insn('0, '0, 5);
      cycle("raw_writer", 1'b1);
      set_insn(32'h20, '0, -1);
      for (int k = 0; k < 3; k++) cycle("raw_stall", 1'b0);
      commit_mask = 32'h20; ctrl_commit = 1'b1;
`ifdef HSV_ISSUE_COMMIT_BYPASS_EN
      cycle("raw_commit_cycle", 1'b1);
      idle_in();
      commit_mask = '0; ctrl_commit = 1'b0;
`else
      cycle("raw_commit_cycle", 1'b0);
      commit_mask = '0; ctrl_commit = 1'b0;
      cycle("raw_late", 1'b1);
      idle_in();
`endif
      chk("raw_pending_clr", {32'd0, pending_mask}, 64'd0);
      commit_n(1);

      // In-flight window: 8 fires fill it, a commit frees a slot one cycle later
      for (int k = 0; k < 8; k++) begin
         set_insn('0, '0, -1);
         cycle("cap_fill", 1'b1);
      end
      cycle("cap_full", 1'b0);
      ctrl_commit = 1'b1;
      cycle("cap_commit_cycle", 1'b0);
      ctrl_commit = 1'b0;
      cycle("cap_ninth", 1'b1);
      idle_in();
      commit_n(8);

      // Dispatch backpressure holds the output register
      out_ready_i = 1'b0;
      set_insn('0, '0, -1);
      cycle("stall_first", 1'b1);
      set_insn('0, '0, -1);
      for (int k = 0; k < 5; k++) begin
         cycle("stall_in_ready", 1'b0);
         chk("stall_out_valid", {63'd0, out_valid_o}, 64'd1);
         chk("stall_token", {60'd0, out_data.common.token}, 64'd14);
         chk("stall_payload", {32'd0, out_data.payload}, {32'd0, pay - 32'd2});
      end
      out_ready_i = 1'b1;
      cycle("stall_release", 1'b1);
      idle_in();
      commit_n(2);

      // Flush with 4 in flight and token 6
      for (int k = 0; k < 2; k++) begin
         set_insn('0, '0, -1);
         cycle("pre_flush", 1'b1);
      end
      idle_in();
      commit_n(2);
      for (int k = 0; k < 4; k++) begin
         set_insn('0, '0, 10 + k);
         cycle("pre_flush_rd", 1'b1);
      end
      chk("pre_flush_token", {60'd0, exp_tok}, 64'd6);
      chk("pre_flush_pending", {32'd0, pending_mask}, 64'h3C00);
      set_insn('0, '0, -1);
      flush_req = 1'b1;
      cycle("flush_block", 1'b0);
      chk("flush_pending", {32'd0, pending_mask}, 64'd0);
      chk("flush_out_valid", {63'd0, out_valid_o}, 64'd0);
      chk("flush_ack_high", {63'd0, flush_ack}, 64'd1);
      cycle("flush_block", 1'b0);
      cycle("flush_block", 1'b0);
      flush_req = 1'b0;
      cycle("flush_ack_tail", 1'b0);
      exp_tok = '0;
      for (int k = 0; k < 8; k++) begin
         set_insn('0, '0, -1);
         cycle("flush_refill", 1'b1);
      end
      cycle("flush_refill_full", 1'b0);
      idle_in();
      commit_n(8);

      // Walk the token to its top value, then wrap; x0 never becomes pending
      while (exp_tok != insn_token'(15)) begin
         set_insn('0, '0, -1);
         cycle("wrap_walk", 1'b1);
         idle_in();
         commit_n(1);
      end
      set_insn('0, '0, 0);
      cycle("wrap_top_x0", 1'b1);
      set_insn(32'h1, '0, 0);
      cycle("wrap_zero_x0", 1'b1);
      idle_in();
      chk("x0_not_pending", {32'd0, pending_mask}, 64'd0);
      commit_n(2);

      // Asynchronous reset while an instruction waits for dispatch
      out_ready_i = 1'b0;
      set_insn('0, '0, 7);
      cycle("pre_reset_issue", 1'b1);
      idle_in();
      chk("pre_reset_valid", {63'd0, out_valid_o}, 64'd1);
      #2 rst_core_n = 1'b0;
      #1;
      chk("arst_out_valid", {63'd0, out_valid_o}, 64'd0);
      chk("arst_flush_ack", {63'd0, flush_ack}, 64'd1);
      chk("arst_pending", {32'd0, pending_mask}, 64'd0);
      if (q.size() != 0) void'(q.pop_front());
      out_ready_i = 1'b1;
      tick();
      chk("queue_drained", 64'(q.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
